// File: rtl/emit_bits.sv
// ============================================================================
// Module   : emit_bits
// Purpose  : MSB-first variable-length serializer with valid/ready output and
//            a one-cycle md_end completion pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module emit_bits (
    input  logic        clk,
    input  logic        rstn,
    input  logic        md_start,
    input  logic [63:0] num_in,
    input  logic [7:0]  len_in,
    input  logic        bit_ready,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        bit_last,
    output logic        busy,
    output logic        md_end
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [6:0] c_MAX_LEN = 7'd64;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_cnt;
    logic [63:0] r_num;
    logic [6:0]  w_len_eff;
    logic [5:0]  w_idx;
    logic        w_xfer;
    logic        w_accept;

    // Lengths beyond the register width saturate at 64 bits.
    assign w_len_eff = (len_in > 8'd64) ? c_MAX_LEN : len_in[6:0];
    // Six-bit wrap maps cnt=64 onto index 63.
    assign w_idx     = r_cnt[5:0] - 6'd1;
    assign w_xfer    = (r_state == S_SEND) && bit_ready;
    assign w_accept  = (r_state == S_IDLE) && md_start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (md_start) begin
                    w_next = (w_len_eff == 7'd0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer && (r_cnt == 7'd1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= 7'd0;
            r_num   <= 64'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_num <= num_in;
                r_cnt <= w_len_eff;
            end else if (w_xfer) begin
                r_cnt <= r_cnt - 7'd1;
            end
        end
    end

    // Every output is a decode of registered state only.
    always_comb begin
        bit_valid = (r_state == S_SEND);
        bit_out   = bit_valid & r_num[w_idx];
        bit_last  = bit_valid && (r_cnt == 7'd1);
        busy      = (r_state != S_IDLE);
        md_end    = (r_state == S_DONE);
    end

endmodule

`default_nettype wire
